imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader: the write side of the byte-addressed, big-endian instruction memory.
- Accepts a framed byte stream over a valid/ready handshake, validates length and checksum, and drives a byte-wide write port into instruction memory.
- Holds the CPU in stall until a valid program is fully written. Sits between the host/debug byte link and the instruction memory write port.

Parameters:
- ADDR_W, 32, width of wr_addr; matches the instruction fetch address width.
- MEM_BYTES, 256, instruction memory capacity in bytes; payload length must be <= MEM_BYTES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session (honoured in IDLE, DONE, ERR).
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- wr_en  output  1  byte write strobe to instruction memory.
- wr_addr  output  ADDR_W  byte address of the write.
- wr_data  output  8  byte to write.
- cpu_hold  output  1  stall request to the CPU fetch stage.
- load_done  output  1  level; program loaded and checksum good.
- load_err  output  1  level; framing, length or checksum failure.

Behaviour:
- Frame format, in order:
  - LEN_HI byte, then LEN_LO byte, forming a 16-bit payload length N.
  - N payload bytes; byte k goes to address k, so the first byte of each word is its MSB (big-endian).
  - One CSUM byte equal to the XOR of LEN_HI, LEN_LO and all payload bytes.
- Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1. in_ready is a function of state only, never of in_valid. The stream may stall (in_valid low) for any number of cycles.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- in_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE, DONE and ERR.
- Transitions:
  - IDLE/DONE/ERR + start -> LEN_HI. This clears load_done, load_err, the byte counter and the running XOR, and sets cpu_hold=1.
  - LEN_HI + transfer -> LEN_LO; the byte is latched as the length high byte.
  - LEN_LO + transfer:
    - N not a multiple of 4 -> ERR.
    - N > MEM_BYTES -> ERR.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA + transfer: issues a write. After the Nth payload byte -> CSUM.
  - CSUM + transfer: byte equals running XOR -> DONE; otherwise -> ERR.
- Write timing: registered, one-cycle latency. The cycle after a DATA transfer, wr_en=1, wr_addr = byte index (0..N-1, zero-extended to ADDR_W) and wr_data = that byte. wr_en is 0 in every other cycle; it is a single-cycle pulse per accepted byte. Back-to-back transfers give back-to-back writes.
- Byte counter is 16 bits and never wraps, because N <= MEM_BYTES <= 65535.
- Running XOR accumulates LEN_HI, LEN_LO and every payload byte on transfer.
- cpu_hold:
  - 1 from reset.
  - Cleared on entry to DONE.
  - Set again by start.
  - Remains 1 in ERR.
- load_done is 1 only in DONE; load_err is 1 only in ERR.
- start outside IDLE/DONE/ERR is ignored.
- Reset (asynchronous, any time, including mid-DATA):
  - state=IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=1, load_done=0, load_err=0.
  - Counter and XOR cleared.
  - Memory contents already written are not rolled back. A pending registered write is dropped.
- ERR entered from CSUM leaves all N payload bytes written; the host must reload.

Test Plan:
- Good load: start; send 00 08 8C 02 00 0E 41 29 00 02 E2 with in_valid continuously high -> 8 writes at addresses 0..7 with data 8C,02,00,0E,41,29,00,02, each one cycle after its transfer; then DONE, load_done=1, cpu_hold=0, load_err=0.
- Bad checksum: same frame with final byte E3 -> 8 writes occur, then ERR, load_err=1, cpu_hold=1. A new start clears load_err and in_ready returns to 1.
- Length violations:
  - LEN=00 06 -> ERR immediately after LEN_LO, zero writes.
  - LEN=01 04 with MEM_BYTES=256 -> ERR, zero writes.
  - LEN=00 00 followed by CSUM 00 -> DONE, zero writes.
- Backpressure: good frame with in_valid toggling 1,0,0,1 patterns -> identical write sequence; no write issued in any cycle following a non-transfer cycle.
- Reset mid-operation: assert rst_n=0 after 3 payload bytes -> all outputs at reset values within the same cycle, no further writes. Then start and a good frame -> normal DONE.
- Start ignored: pulse start while in DATA -> no state change; the load completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Write side of the byte-addressed, big-endian instruction memory. Receives a
//   framed byte stream (LEN_HI, LEN_LO, N payload bytes, CSUM) over a
//   valid/ready handshake. It checks the length and the XOR checksum and writes
//   each payload byte k to memory address k, which makes the images big-endian.
//   The CPU fetch stage is held in stall until a complete, verified program
//   has been written.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a load (honoured in IDLE/DONE/ERR)
//   in_data    in   stream byte
//   in_valid   in   in_data is valid
//   in_ready   out  loader accepts in_data this cycle (depends on state only)
//   wr_en      out  byte write strobe, one cycle after each payload transfer
//   wr_addr    out  byte address of the write (payload index, zero-extended)
//   wr_data    out  byte to write
//   cpu_hold   out  stall request to the CPU fetch stage
//   load_done  out  level: program loaded and checksum good
//   load_err   out  level: length or checksum failure
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q,   state_d;
    logic [15:0]       len_q,     len_d;
    logic [15:0]       cnt_q,     cnt_d;
    logic [7:0]        xor_q,     xor_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              hold_q,    hold_d;

    logic              xfer;
    logic [15:0]       len_full;
    logic [15:0]       cnt_plus;
    logic              len_too_big;
    logic              len_unaligned;

    // Ready is purely a function of the current state so a host can never
    // form a combinational loop through in_valid.
    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);

    assign xfer = in_valid && in_ready;

    // Full length as it will be once the low byte currently on the bus lands.
    assign len_full      = {len_q[15:8], in_data};
    assign len_unaligned = (len_full[1:0] != 2'b00);
    assign len_too_big   = (32'(len_full) > 32'(MEM_BYTES));
    assign cnt_plus      = cnt_q + 16'd1;

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = hold_q;
    assign load_done = (state_q == S_DONE);
    assign load_err  = (state_q == S_ERR);

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        xor_d     = xor_q;
        wr_en_d   = 1'b0;          // strobe is a single-cycle pulse
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    len_d   = 16'd0;
                    cnt_d   = 16'd0;
                    xor_d   = 8'd0;
                    hold_d  = 1'b1;
                end
            end

            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    xor_d       = xor_q ^ in_data;
                    state_d     = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    xor_d = xor_q ^ in_data;
                    if (len_unaligned || len_too_big) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(cnt_q);
                    wr_data_d = in_data;
                    xor_d     = xor_q ^ in_data;
                    cnt_d     = cnt_plus;
                    if (cnt_plus == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (xfer) begin
                    if (in_data == xor_q) begin
                        state_d = S_DONE;
                        hold_d  = 1'b0;    // release the CPU only on a good image
                    end else begin
                        state_d = S_ERR;   // payload stays written; host reloads
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register. Reset drops any pending write and re-asserts the stall.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= 16'd0;
            cnt_q     <= 16'd0;
            xor_q     <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            xor_q     <= xor_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives framed byte streams into imem_loader. The expected write list and the
// final outcome come from a frame-level reference model. That model parses the
// length, the payload and the checksum directly out of the frame bytes.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 256;
    localparam int FRAME_BUDGET = 5000;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Current frame and the reference model's prediction for it.
    logic [7:0] byte_q[$];
    int         exp_consumed;
    int         exp_nwr;
    bit         exp_done;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: decide acceptance from length/checksum rules.
    task automatic model_frame();
        int         n;
        logic [7:0] x;
        n = {24'd0, byte_q[0], byte_q[1]};
        if ((n % 4) != 0 || n > MEM_BYTES) begin
            exp_consumed = 2;
            exp_nwr      = 0;
            exp_done     = 1'b0;
        end else begin
            x = 8'd0;
            for (int i = 0; i < n + 2; i++) x ^= byte_q[i];
            exp_consumed = n + 3;
            exp_nwr      = n;
            exp_done     = (byte_q[n + 2] == x);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_ready", 32'(in_ready), 32'd1);
        check_eq("start_done", 32'(load_done), 32'd0);
        check_eq("start_err", 32'(load_err), 32'd0);
        check_eq("start_hold", 32'(cpu_hold), 32'd1);
        check_eq("start_wren", 32'(wr_en), 32'd0);
    endtask

    task automatic idle_check(input int cycles, input bit ready_exp);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_eq("idle_wren", 32'(wr_en), 32'd0);
            check_eq("idle_ready", 32'(in_ready), 32'(ready_exp));
        end
    endtask

    // Stream byte_q into the DUT. vprob is the percentage chance that in_valid
    // is high on any cycle. start_at pulses start when that byte index is
    // next. abort_at returns early once that many bytes have transferred.
    task automatic send_frame(input int vprob, input int start_at,
                              input int abort_at, output bit aborted);
        int  idx;
        int  cyc;
        bit  drive_v;
        bit  drive_rdy;
        bit  pend;
        bit  start_used;
        int  paddr;
        logic [7:0] pdata;
        model_frame();
        idx = 0; cyc = 0; drive_v = 0; drive_rdy = 0; start_used = 0;
        aborted = 0;
        paddr = 0;
        pdata = 8'd0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            pend  = 0;
            if (drive_v && drive_rdy) begin
                if (idx >= 2 && (idx - 2) < exp_nwr) begin
                    pend  = 1;
                    paddr = idx - 2;
                    pdata = byte_q[idx];
                end
                idx++;
            end
            check_eq("wr_en", 32'(wr_en), 32'(pend));
            if (pend) begin
                check_eq("wr_addr", wr_addr, 32'(paddr));
                check_eq("wr_data", 32'(wr_data), 32'(pdata));
            end
            if (idx == abort_at) begin
                in_valid = 1'b0;
                aborted  = 1;
                return;
            end
            if (idx >= exp_consumed) begin
                in_valid = 1'b0;
                check_eq("end_ready", 32'(in_ready), 32'd0);
                check_eq("end_done", 32'(load_done), 32'(exp_done));
                check_eq("end_err", 32'(load_err), 32'(!exp_done));
                check_eq("end_hold", 32'(cpu_hold), 32'(!exp_done));
                return;
            end
            check_eq("ready", 32'(in_ready), 32'd1);
            if (cyc >= FRAME_BUDGET) begin
                check_eq("frame_timeout", 32'(idx), 32'(exp_consumed));
                in_valid = 1'b0;
                aborted  = 1;
                return;
            end
            drive_v   = ($urandom_range(99) < vprob);
            drive_rdy = 1;
            in_valid  = drive_v;
            in_data   = drive_v ? byte_q[idx] : 8'($urandom);
            if (idx == start_at && !start_used) begin
                start      = 1'b1;
                start_used = 1;
            end
            cyc++;
        end
    endtask

    task automatic make_random();
        int         n;
        int         r;
        logic [7:0] x;
        logic [7:0] b;
        r = int'($urandom_range(9));
        if (r == 0)      n = 0;
        else if (r == 1) n = int'($urandom_range(63)) * 4 + int'($urandom_range(1, 3));
        else if (r == 2) n = 260 + 4 * int'($urandom_range(100));
        else             n = 4 * int'($urandom_range(1, 64));
        byte_q.delete();
        byte_q.push_back(8'(n >> 8));
        byte_q.push_back(8'(n));
        if ((n % 4) == 0 && n <= MEM_BYTES) begin
            x = byte_q[0] ^ byte_q[1];
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                byte_q.push_back(b);
                x ^= b;
            end
            if ($urandom_range(3) == 0) x ^= 8'(1 << $urandom_range(7));
            byte_q.push_back(x);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_wren"}, 32'(wr_en), 32'd0);
        check_eq({tag, "_addr"}, wr_addr, 32'd0);
        check_eq({tag, "_data"}, 32'(wr_data), 32'd0);
        check_eq({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check_eq({tag, "_done"}, 32'(load_done), 32'd0);
        check_eq({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        bit ab;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        // Reset state
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_check(2, 1'b0);
        check_eq("idle_hold", 32'(cpu_hold), 32'd1);

        // Good load, continuous valid
        byte_q = '{8'h00, 8'h08, 8'h8C, 8'h02, 8'h00, 8'h0E,
                   8'h41, 8'h29, 8'h00, 8'h02, 8'hE2};
        do_start();
        send_frame(100, -1, -1, ab);
        $display("good frame: done=%0b err=%0b hold=%0b", load_done, load_err, cpu_hold);
        idle_check(2, 1'b0);

        // Bad checksum
        byte_q[10] = 8'hE3;
        do_start();
        send_frame(100, -1, -1, ab);
        $display("bad csum frame: done=%0b err=%0b hold=%0b", load_done, load_err, cpu_hold);

        // Length violations and the empty program
        byte_q = '{8'h00, 8'h06};
        do_start();
        send_frame(100, -1, -1, ab);
        $display("len 0006: err=%0b", load_err);
        byte_q = '{8'h01, 8'h04};
        do_start();
        send_frame(100, -1, -1, ab);
        $display("len 0104: err=%0b", load_err);
        byte_q = '{8'h00, 8'h00, 8'h00};
        do_start();
        send_frame(100, -1, -1, ab);
        $display("len 0000: done=%0b", load_done);

        // Backpressure
        byte_q = '{8'h00, 8'h08, 8'h8C, 8'h02, 8'h00, 8'h0E,
                   8'h41, 8'h29, 8'h00, 8'h02, 8'hE2};
        do_start();
        send_frame(40, -1, -1, ab);
        $display("backpressure frame: done=%0b", load_done);

        // Reset after three payload bytes, then a clean reload
        do_start();
        send_frame(100, -1, 5, ab);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(3, 1'b0);
        $display("mid-data reset applied");
        do_start();
        send_frame(100, -1, -1, ab);
        $display("reload after reset: done=%0b", load_done);

        // start pulsed during DATA is ignored
        do_start();
        send_frame(70, 5, -1, ab);
        $display("start during data: done=%0b", load_done);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            make_random();
            do_start();
            send_frame(int'($urandom_range(30, 100)), -1, -1, ab);
            $display("random frame %0d: len=%0d done=%0b err=%0b", f,
                     {byte_q[0], byte_q[1]}, load_done, load_err);
        end
        idle_check(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
